// File: rtl/jt10_adpcm_pkg.sv
// Shared constants for the ADPCM-X address counter: channel state encoding and page size.
package jt10_adpcm_pkg;
  localparam int PAGE_W = 8;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
endpackage

// File: rtl/jt10_adpcmx_cnt_if.sv
// Register-bank side inputs and fetch-side outputs of the ADPCM-X address counter.
interface jt10_adpcmx_cnt_if #(
  parameter int CH = 2,
  parameter int DW = 16,
  parameter int AW = 24
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW  = AW - 8;

  logic                cen;
  logic [CH*DW-1:0]    delta_n;
  logic [CH-1:0]       on;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       key_on;
  logic [CH*PW-1:0]    astart;
  logic [CH*PW-1:0]    aloop;
  logic [CH*PW-1:0]    aend;
  logic [CH-1:0]       arepeat;
  logic [CH-1:0]       clr_flag;
  logic [AW-1:0]       addr;
  logic                nibble_sel;
  logic [CHW-1:0]      ch;
  logic                adv;
  logic [CH-1:0]       chon;
  logic [CH-1:0]       flag;

  modport master (
    output cen, delta_n, on, clr, key_on, astart, aloop, aend, arepeat, clr_flag,
    input  addr, nibble_sel, ch, adv, chon, flag
  );

  modport slave (
    input  cen, delta_n, on, clr, key_on, astart, aloop, aend, arepeat, clr_flag,
    output addr, nibble_sel, ch, adv, chon, flag
  );
endinterface

// File: rtl/jt10_adpcmx_step.sv
// Combinational next-state of one channel: phase accumulator plus start/loop/end address sequencing.
module jt10_adpcmx_step
  import jt10_adpcm_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 24
) (
  input  logic               i_on,
  input  logic               i_arepeat,
  input  logic [DW-1:0]      i_cnt,
  input  logic [DW-1:0]      i_delta,
  input  logic [1:0]         i_st,
  input  logic [AW-1:0]      i_addr,
  input  logic               i_nib,
  input  logic [AW-PAGE_W-1:0] i_astart,
  input  logic [AW-PAGE_W-1:0] i_aloop,
  input  logic [AW-PAGE_W-1:0] i_aend,
  output logic [DW-1:0]      o_cnt,
  output logic [1:0]         o_st,
  output logic [AW-1:0]      o_addr,
  output logic               o_nib,
  output logic               o_carry,
  output logic               o_end
);
  logic [DW:0] w_sum;
  logic [AW:0] w_pos, w_last, w_inc;

  assign w_sum   = {1'b0, i_cnt} + {1'b0, i_delta};
  assign o_carry = i_on & w_sum[DW];
  assign o_cnt   = i_on ? w_sum[DW-1:0] : i_cnt;

  // {addr,nib} is a nibble index; the last nibble of the end page is the final one played
  assign w_pos  = {i_addr, i_nib};
  assign w_last = {i_aend, {PAGE_W{1'b1}}, 1'b1};
  assign w_inc  = w_pos + (AW+1)'(1);

  always_comb begin
    o_st   = i_st;
    o_addr = i_addr;
    o_nib  = i_nib;
    o_end  = 1'b0;
    if (o_carry) begin
      case (i_st)
        ST_ARMED: begin
          {o_addr, o_nib} = {i_astart, {PAGE_W{1'b0}}, 1'b0};
          o_st            = ST_PLAY;
        end
        ST_PLAY: begin
          if (w_pos < w_last)
            {o_addr, o_nib} = w_inc;
          else if (i_arepeat)
            {o_addr, o_nib} = {i_aloop, {PAGE_W{1'b0}}, 1'b0};
          else begin
            o_st  = ST_OFF;
            o_end = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/jt10_adpcmx_cnt.sv
// Round-robin ADPCM-X address/phase counter: one shared step datapath serves CH channel slots.
module jt10_adpcmx_cnt
  import jt10_adpcm_pkg::*;
#(
  parameter int CH = 2,
  parameter int DW = 16,
  parameter int AW = 24
) (
  input  logic clk,
  input  logic rst_n,
  jt10_adpcmx_cnt_if.slave bus
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW  = AW - PAGE_W;

  logic [CHW-1:0] r_slot;
  logic [DW-1:0]  r_cnt  [CH];
  logic [AW-1:0]  r_addr [CH];
  logic [1:0]     r_st   [CH];
  logic [CH-1:0]  r_nib;
  logic [CH-1:0]  r_flag;

  logic [CHW-1:0] r_ch;
  logic [AW-1:0]  r_oaddr;
  logic           r_onib;
  logic           r_adv;

  logic [DW-1:0]  w_cnt_nx;
  logic [1:0]     w_st_nx;
  logic [AW-1:0]  w_addr_nx;
  logic           w_nib_nx;
  logic           w_carry;
  logic           w_end;
  logic           w_on;
  logic           w_ovr;

  assign w_on  = bus.on[r_slot];
  // Level/pulse controls on the serviced channel take precedence over its step this clock
  assign w_ovr = ~w_on | bus.clr[r_slot] | bus.key_on[r_slot];

  jt10_adpcmx_step #(.DW(DW), .AW(AW)) u_step (
    .i_on      (w_on),
    .i_arepeat (bus.arepeat[r_slot]),
    .i_cnt     (r_cnt[r_slot]),
    .i_delta   (bus.delta_n[int'(r_slot)*DW +: DW]),
    .i_st      (r_st[r_slot]),
    .i_addr    (r_addr[r_slot]),
    .i_nib     (r_nib[r_slot]),
    .i_astart  (bus.astart[int'(r_slot)*PW +: PW]),
    .i_aloop   (bus.aloop[int'(r_slot)*PW +: PW]),
    .i_aend    (bus.aend[int'(r_slot)*PW +: PW]),
    .o_cnt     (w_cnt_nx),
    .o_st      (w_st_nx),
    .o_addr    (w_addr_nx),
    .o_nib     (w_nib_nx),
    .o_carry   (w_carry),
    .o_end     (w_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_ch    <= '0;
      r_oaddr <= '0;
      r_onib  <= 1'b0;
      r_adv   <= 1'b0;
      r_nib   <= '0;
      r_flag  <= '0;
      for (int c = 0; c < CH; c++) begin
        r_cnt[c]  <= '0;
        r_addr[c] <= '0;
        r_st[c]   <= ST_OFF;
      end
    end else begin
      if (bus.cen) begin
        r_slot  <= (r_slot == CHW'(CH-1)) ? '0 : r_slot + 1'b1;
        r_ch    <= r_slot;
        r_adv   <= w_carry | ~w_on;
        r_oaddr <= w_ovr ? r_addr[r_slot] : w_addr_nx;
        r_onib  <= w_ovr ? r_nib[r_slot]  : w_nib_nx;
      end
      for (int c = 0; c < CH; c++) begin
        if (!bus.on[c] || bus.clr[c]) begin
          r_st[c]  <= ST_OFF;
          r_cnt[c] <= '0;
        end else if (bus.key_on[c]) begin
          r_st[c]  <= ST_ARMED;
        end else if (bus.cen && r_slot == CHW'(c)) begin
          r_cnt[c]  <= w_cnt_nx;
          r_st[c]   <= w_st_nx;
          r_addr[c] <= w_addr_nx;
          r_nib[c]  <= w_nib_nx;
        end
        if (bus.cen && r_slot == CHW'(c) && !w_ovr && w_end)
          r_flag[c] <= 1'b1;
        else if (bus.clr_flag[c])
          r_flag[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.chon = '0;
    for (int c = 0; c < CH; c++)
      bus.chon[c] = (r_st[c] == ST_PLAY);
  end

  assign bus.ch         = r_ch;
  assign bus.addr       = r_oaddr;
  assign bus.nibble_sel = r_onib;
  assign bus.adv        = r_adv;
  assign bus.flag       = r_flag;
endmodule

// File: tb/tb_jt10_adpcmx_cnt.sv
// Scoreboard bench: a nibble-position reference model predicts every cen output; a monitor checks them.
module tb_jt10_adpcmx_cnt;
  localparam int CH = 2;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int PW = AW - 8;
  localparam int M_OFF = 0, M_ARMED = 1, M_PLAY = 2;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    bit          nib;
    bit          adv;
    logic [31:0] chon;
    logic [31:0] flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt10_adpcmx_cnt_if #(.CH(CH), .DW(DW), .AW(AW)) bus ();
  jt10_adpcmx_cnt #(.CH(CH), .DW(DW), .AW(AW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int     n_chk = 0;
  int     n_fail = 0;
  exp_t   q[$];

  // Reference model: playback position as an absolute nibble index
  int     m_slot;
  int     m_cnt  [CH];
  longint m_pos  [CH];
  int     m_st   [CH];
  bit     m_flag [CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint pg(input logic [CH*PW-1:0] v, input int c);
    return longint'(v[c*PW +: PW]);
  endfunction

  function automatic void model_reset();
    m_slot = 0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_pos[c] = 0; m_st[c] = M_OFF; m_flag[c] = 0;
    end
  endfunction

  function automatic void model_step();
    exp_t e;
    int   s, d, sum;
    bit   carry, ovr, endev;
    endev = 0;
    s = m_slot;
    e.ch = 0; e.addr = 0; e.nib = 0; e.adv = 0; e.chon = 0; e.flag = 0;
    if (bus.cen) begin
      d     = int'(bus.delta_n[s*DW +: DW]);
      sum   = m_cnt[s] + d;
      carry = bus.on[s] && sum >= (1 << DW);
      ovr   = !bus.on[s] || bus.clr[s] || bus.key_on[s];
      if (!ovr) begin
        m_cnt[s] = sum % (1 << DW);
        if (carry && m_st[s] == M_ARMED) begin
          m_pos[s] = pg(bus.astart, s) * 512;
          m_st[s]  = M_PLAY;
        end else if (carry && m_st[s] == M_PLAY) begin
          if (m_pos[s] < pg(bus.aend, s) * 512 + 511) m_pos[s]++;
          else if (bus.arepeat[s]) m_pos[s] = pg(bus.aloop, s) * 512;
          else begin m_st[s] = M_OFF; endev = 1; end
        end
      end
      e.ch   = s;
      e.addr = 32'(m_pos[s] / 2);
      e.nib  = (m_pos[s] % 2) == 1;
      e.adv  = carry || !bus.on[s];
    end
    for (int c = 0; c < CH; c++) begin
      if (!bus.on[c] || bus.clr[c]) begin m_st[c] = M_OFF; m_cnt[c] = 0; end
      else if (bus.key_on[c]) m_st[c] = M_ARMED;
      if (endev && c == s) m_flag[c] = 1;
      else if (bus.clr_flag[c]) m_flag[c] = 0;
    end
    if (bus.cen) begin
      m_slot = (m_slot + 1) % CH;
      for (int c = 0; c < CH; c++) begin
        e.chon[c] = (m_st[c] == M_PLAY);
        e.flag[c] = m_flag[c];
      end
      q.push_back(e);
    end
  endfunction

  // Called at a falling edge with inputs already set; returns at the next falling edge
  task automatic tick(input bit c);
    bus.cen = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (rst_n && bus.cen) begin
      exp_t e;
      #1;
      if (q.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("ch",         32'(bus.ch), 32'(e.ch));
        chk("addr",       32'(bus.addr), e.addr);
        chk("nibble_sel", 32'(bus.nibble_sel), 32'(e.nib));
        chk("adv",        32'(bus.adv), 32'(e.adv));
        chk("chon",       32'(bus.chon), e.chon);
        chk("flag",       32'(bus.flag), e.flag);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ch"},   32'(bus.ch), 32'd0);
    chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
    chk({tag, "_nib"},  32'(bus.nibble_sel), 32'd0);
    chk({tag, "_adv"},  32'(bus.adv), 32'd0);
    chk({tag, "_chon"}, 32'(bus.chon), 32'd0);
    chk({tag, "_flag"}, 32'(bus.flag), 32'd0);
  endtask

  initial begin
    bus.cen = 0; bus.delta_n = '0; bus.on = '0; bus.clr = '0; bus.key_on = '0;
    bus.astart = '0; bus.aloop = '0; bus.aend = '0; bus.arepeat = '0; bus.clr_flag = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (4) tick(1);

    // Single-shot sample on ch0: one page, played to the end
    bus.delta_n[15:0] = 16'h8000;
    bus.astart[15:0] = 16'h0010; bus.aend[15:0] = 16'h0010;
    bus.on = 2'b01; bus.key_on = 2'b01;
    tick(0);
    bus.key_on = '0;
    repeat (3) tick(1);
    chk("first_addr", 32'(bus.addr), 32'h001000);
    chk("first_nib",  32'(bus.nibble_sel), 32'd0);
    chk("first_chon", 32'(bus.chon[0]), 32'd1);
    repeat (2044) tick(1);
    chk("last_addr", 32'(bus.addr), 32'h0010FF);
    chk("last_nib",  32'(bus.nibble_sel), 32'd1);
    repeat (3) tick(1);
    bus.clr_flag = 2'b01;
    tick(1);
    chk("end_chon",      32'(bus.chon[0]), 32'd0);
    chk("end_flag_wins", 32'(bus.flag[0]), 32'd1);
    tick(0);
    chk("flag_cleared", 32'(bus.flag[0]), 32'd0);
    bus.clr_flag = '0;

    // Looping sample: end page wraps back to the loop page
    bus.aloop[15:0] = 16'h0011; bus.aend[15:0] = 16'h0012; bus.arepeat = 2'b01;
    bus.key_on = 2'b01;
    tick(0);
    bus.key_on = '0;
    repeat (6400) tick(1);
    chk("loop_chon", 32'(bus.chon[0]), 32'd1);
    chk("loop_flag", 32'(bus.flag[0]), 32'd0);

    // Fast ch1 against a crawling ch0
    bus.delta_n = {16'hFFFF, 16'h0001};
    bus.astart[31:16] = 16'h0020; bus.aloop[31:16] = 16'h0020; bus.aend[31:16] = 16'h0021;
    bus.on = 2'b11; bus.key_on = 2'b11;
    tick(0);
    bus.key_on = '0;
    repeat (300) tick(1);

    // key_on colliding with clr, then retrigger while playing
    bus.key_on = 2'b01; bus.clr = 2'b01;
    tick(0);
    chk("clr_beats_key", 32'(bus.chon[0]), 32'd0);
    bus.clr = '0; bus.delta_n[15:0] = 16'h8000;
    tick(0);
    bus.key_on = '0;
    repeat (20) tick(1);
    bus.key_on = 2'b01;
    tick(1);
    bus.key_on = '0;
    repeat (20) tick(1);

    // Randomized traffic with small page ranges so ends and loops occur often
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(63) == 0) bus.on[c] = ~bus.on[c];
        bus.clr[c]      = ($urandom_range(127) == 0);
        bus.key_on[c]   = ($urandom_range(31) == 0);
        bus.clr_flag[c] = ($urandom_range(15) == 0);
        if ($urandom_range(63) == 0) bus.arepeat[c] = ~bus.arepeat[c];
        if ($urandom_range(255) == 0) begin
          int st;
          st = int'($urandom_range(3));
          bus.astart[c*PW +: PW] = 16'(st);
          bus.aloop[c*PW +: PW]  = 16'(st + int'($urandom_range(1)));
          bus.aend[c*PW +: PW]   = 16'(st + int'($urandom_range(2)));
        end
        if ($urandom_range(127) == 0) bus.delta_n[c*DW +: DW] = 16'($urandom_range(16'hFFFF, 16'h4000));
      end
      if (i == 2500) begin
        bus.cen = 0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;
      end else begin
        tick($urandom_range(1) == 1);
      end
    end
    bus.cen = 0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jt10_adpcmx_cnt.md
# jt10_adpcmx_cnt

Time-multiplexed, parametrised ADPCM address/phase counter serving `CH` channels from one shared datapath. Each `cen` pulse services one channel slot in round-robin order: phase accumulation, start/loop/end address sequencing and end-of-sample flagging. Sits between the ADPCM register bank and the ROM-fetch/decoder pipeline. Adds a loop point separate from the start address and parametrised widths and channel count.

## Interface
- `CH`, 2: channel count, ≥1; `CHW = max(1, $clog2(CH))`
- `DW`, 16: phase-step (delta) width
- `AW`, 24: byte-address width; start/loop/end are page numbers of `AW-8` bits (page = 256 bytes)

- `rst_n`  in  1: asynchronous active-low reset
- `clk`  in  1: the single clock
- `cen`  in  1: slot advance enable
- `delta_n`  in  `CH*DW`: per-channel phase step, channel c at `[c*DW +: DW]` (same packing for all vectors)
- `on`  in  `CH`: channel enable level
- `clr`  in  `CH`: synchronous channel clear
- `key_on`  in  `CH`: single-clock start pulse, not `cen`-qualified
- `astart`, `aloop`, `aend`  in  `CH*(AW-8)`: start, loop and end pages
- `arepeat`  in  `CH`: loop enable
- `clr_flag`  in  `CH`: flag clear
- `addr`  out  `AW`: address for serviced slot
- `nibble_sel`  out  1: nibble within byte
- `ch`  out  `CHW`: slot index the outputs belong to
- `adv`  out  1: serviced slot advances this step
- `chon`  out  `CH`: channel playing
- `flag`  out  `CH`: end-of-sample flag, sticky

## Operation
- Slot counter `slot` goes 0..CH-1 and wraps. It increments on every `cen`.
- Each channel holds `cnt[DW]`, `addr[AW]`, `nib` and a state from {OFF, ARMED, PLAY}.
- Any clock, highest priority first:
  - `!on[c] | clr[c]`: state OFF, `cnt`=0.
  - Else `key_on[c]`: state ARMED. This applies from any state, including PLAY (retrigger).
  - These actions override a `cen` update of the same channel in the same clock.
- On `cen`, for `s = slot`:
  - `{carry,cnt} = cnt + delta`, zero-extended, DW+1 bits. The accumulator runs only when `on[s]`.
  - ARMED & carry: `addr = {astart,8'h00}`, `nib`=0, state PLAY.
  - PLAY & carry & `{addr,nib} < {aend,8'hFF,1}`: `{addr,nib}` += 1.
  - PLAY & carry at end & `arepeat`: `addr = {aloop,8'h00}`, `nib`=0, stay PLAY. No flag.
  - PLAY & carry at end & `!arepeat`: state OFF, set `flag[s]`.
- `chon[c]` = (state==PLAY).
- `flag[c]`: set on the end event, cleared by `clr_flag[c]`. Set wins if both occur in the same clock.
- Registered outputs on each `cen`:
  - `ch = s`; `addr` and `nibble_sel` = slot s post-update values.
  - `adv` = carry, or 1 when `!on[s]` so downstream stages flush to reset values.

## Timing
- Reset: `slot`, all `cnt`, `addr`, `nib`, `ch`, `adv`, `nibble_sel`, `chon` and `flag` are 0. All states are OFF.
- Outputs change on the clock edge where `cen`=1, are valid from the next cycle, and hold until the next `cen`.
- Latency is one `clk` from the servicing `cen` to the output.
- Per-channel step rate is `cen` rate / CH.
- `key_on` is captured on any clock. The first address appears on the first carry of that channel after capture, never on the same edge.
- Reset asserted mid-operation clears everything immediately. There is no partial state.

## Structure
- Shared package `jt10_adpcm_pkg`: state encoding (OFF/ARMED/PLAY) and page width constant `PAGE_W=8`.
- One sub-module, `jt10_adpcmx_step`: combinational next-state for a single channel (accumulator, address compare/increment, loop/end decision). It is instantiated once and muxed by `slot`.
- Per-channel storage stays in the top level as arrays.

## Test plan
- Reset with all inputs 0 → all outputs 0. Subsequent `cen` pulses give `ch` sequence 0,1,0,1 and `adv`=1.
- CH=2, ch0 `delta`=0x8000, `astart`=`aend`=0x0010, key_on:
  - First carry on the 2nd ch0 visit → `addr`=0x001000, `nibble_sel`=0, `chon[0]`=1.
  - After 511 further carries → 0x0010FF/1.
  - Next carry → `chon[0]`=0, `flag[0]`=1.
- `arepeat`=1, `astart`=0x0010, `aloop`=0x0011, `aend`=0x0012: after 0x0012FF/1, next carry → `addr`=0x001100, `nib` 0, `chon` stays 1, `flag` stays 0.
- ch1 `delta`=0xFFFF while ch0 `delta`=0x0001: ch1 `adv`=1 on every visit except the first; ch0 gets no carry for 65535 visits. ch0 and ch1 addresses are independent.
- `key_on[0]` and `clr[0]` in the same clock → state OFF, `chon[0]`=0. A later `key_on` during PLAY → ARMED, then restart at `astart`.
- `flag[0]` set and `clr_flag[0]` in the same clock → `flag[0]`=1. `clr_flag[0]` alone next clock → 0.
